// File: rtl/mdu_iter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mdu_iter
// Brief    : Iterative multiply/divide unit with HI/LO pair for the EX stage.
//            Radix-2 shift-add multiply, radix-2 restoring divide, MADD/MSUB
//            accumulate, abort on exception, one-cycle completion pulse.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_iter #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] HILO_INIT = '0
) (
    input  logic             Clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic [2:0]       Op,
    input  logic             Start,
    input  logic             We,
    input  logic             HiLo,
    input  logic             if_exception,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    // Counter must hold WIDTH-1; WIDTH is expected to be at least 2.
    localparam int               CNT_W      = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    // Latched operation attributes
    logic             r_is_div;   // DIVU/DIV
    logic             r_acc;      // MADD(U)/MSUB(U)
    logic             r_sub;      // MSUB(U) when r_acc
    logic             r_neg_res;  // negate product / quotient in FIX
    logic             r_neg_rem;  // negate remainder in FIX (dividend sign)
    logic [WIDTH-1:0] r_a_raw;    // original dividend, for divide-by-zero HI
    logic [WIDTH-1:0] r_b;        // divisor / multiplicand magnitude

    // Work pair: multiply {partial hi, multiplier/low product};
    // divide {partial remainder, dividend/quotient}.
    logic [WIDTH-1:0] r_wh;
    logic [WIDTH-1:0] r_wl;

    // Launch-time operand magnitudes
    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;

    // Control decodes
    logic w_idle_ok;
    logic w_write;
    logic w_launch;
    logic w_step;
    logic w_commit;

    // Iteration datapath
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_sh;
    logic [WIDTH:0]   w_div_diff;
    logic             w_div_ok;

    // Final correction datapath
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0] w_hilo;
    logic [2*WIDTH-1:0] w_mul_res;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [2*WIDTH-1:0] w_div_res;
    logic [2*WIDTH-1:0] w_fix_res;

    assign w_neg_a = Op[0] & D1[WIDTH-1];
    assign w_neg_b = Op[0] & D2[WIDTH-1];
    assign w_mag_a = w_neg_a ? -D1 : D1;
    assign w_mag_b = w_neg_b ? -D2 : D2;

    // Exception has top priority in IDLE, then a direct write, then a launch.
    assign w_idle_ok = (r_state == c_IDLE) && !if_exception;
    assign w_write   = w_idle_ok && We;
    assign w_launch  = w_idle_ok && !We && Start;
    assign w_step    = (r_state == c_CALC) && !if_exception;
    assign w_commit  = (r_state == c_FIX)  && !if_exception;

    // Shift-add: conditionally add the multiplicand to the upper half, then
    // shift the whole pair right so the next multiplier bit reaches bit 0.
    assign w_mul_sum = {1'b0, r_wh} + (r_wl[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});

    // Restoring divide: bring in the next dividend bit and trial-subtract.
    assign w_div_sh   = {r_wh, r_wl[WIDTH-1]};
    assign w_div_diff = w_div_sh - {1'b0, r_b};
    assign w_div_ok   = ~w_div_diff[WIDTH];

    assign w_prod    = {r_wh, r_wl};
    assign w_prod_s  = r_neg_res ? -w_prod : w_prod;
    assign w_hilo    = {r_hi, r_lo};
    assign w_mul_res = !r_acc ? w_prod_s :
                       r_sub  ? (w_hilo - w_prod_s) : (w_hilo + w_prod_s);
    assign w_quo     = r_neg_res ? -r_wl : r_wl;
    assign w_rem     = r_neg_rem ? -r_wh : r_wh;
    // A zero divisor magnitude only arises from a zero divisor.
    assign w_div_res = (r_b == '0) ? {r_a_raw, {WIDTH{1'b1}}} : {w_rem, w_quo};
    assign w_fix_res = r_is_div ? w_div_res : w_mul_res;

    // Sequencer: IDLE -> CALC (WIDTH iterations) -> FIX -> IDLE, abortable.
    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_commit;
            case (r_state)
                c_IDLE: begin
                    if (w_launch) begin
                        r_state <= c_CALC;
                        r_cnt   <= c_CNT_LAST;
                        r_busy  <= 1'b1;
                    end
                end
                c_CALC: begin
                    if (if_exception) begin
                        r_state <= c_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                        if (r_cnt == '0) begin
                            r_state <= c_FIX;
                        end
                    end
                end
                c_FIX: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Operand capture at launch and one radix-2 iteration per CALC cycle.
    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            r_is_div  <= 1'b0;
            r_acc     <= 1'b0;
            r_sub     <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_a_raw   <= '0;
            r_b       <= '0;
            r_wh      <= '0;
            r_wl      <= '0;
        end else if (w_launch) begin
            r_is_div  <= ~Op[2] & Op[1];
            r_acc     <= Op[2];
            r_sub     <= Op[1];
            r_neg_res <= w_neg_a ^ w_neg_b;
            r_neg_rem <= w_neg_a;
            r_a_raw   <= D1;
            r_b       <= w_mag_b;
            r_wh      <= '0;
            r_wl      <= w_mag_a;
        end else if (w_step) begin
            if (r_is_div) begin
                r_wh <= w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
                r_wl <= {r_wl[WIDTH-2:0], w_div_ok};
            end else begin
                r_wh <= w_mul_sum[WIDTH:1];
                r_wl <= {w_mul_sum[0], r_wl[WIDTH-1:1]};
            end
        end
    end

    // Architectural HI/LO: direct writes in IDLE, results at a clean FIX.
    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            r_hi <= HILO_INIT;
            r_lo <= HILO_INIT;
        end else if (w_write) begin
            if (HiLo) begin
                r_lo <= D1;
            end else begin
                r_hi <= D1;
            end
        end else if (w_commit) begin
            r_hi <= w_fix_res[2*WIDTH-1:WIDTH];
            r_lo <= w_fix_res[WIDTH-1:0];
        end
    end

    assign Busy = r_busy;
    assign Done = r_done;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mdu_iter
// Brief    : Self-checking bench for mdu_iter: directed cases, aborts, reset
//            and randomized operations against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_iter;

    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         resetn;
    logic [W-1:0] D1, D2;
    logic [2:0]   Op;
    logic         Start, We, HiLo, if_exception;
    logic         Busy, Done;
    logic [W-1:0] HI, LO;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] m_hi, m_lo;   // reference HI/LO

    mdu_iter #(.WIDTH(W), .HILO_INIT('0)) dut (
        .Clk(Clk), .resetn(resetn), .D1(D1), .D2(D2), .Op(Op),
        .Start(Start), .We(We), .HiLo(HiLo), .if_exception(if_exception),
        .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference: result {HI,LO} of an op from plain integer arithmetic.
    function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] acc);
        logic [63:0] p;
        int sa, sb;
        sa = a;
        sb = b;
        if (op[0]) p = 64'(longint'(sa) * longint'(sb));
        else       p = {32'b0, a} * {32'b0, b};
        case (op)
            3'b000, 3'b001: return p;
            3'b010: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            3'b011: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            3'b100, 3'b101: return acc + p;
            default:        return acc - p;
        endcase
    endfunction

    // Launch an op in the current cycle and check Busy/Done timing and result.
    // With noise set, Start/We with other data are pulsed while Busy.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit noise);
        logic [63:0] exp;
        logic [1:0]  bd_bad;
        exp   = ref_op(op, a, b, {m_hi, m_lo});
        Op    = op; D1 = a; D2 = b; Start = 1'b1;
        tick();
        Start  = 1'b0;
        bd_bad = 2'b10;
        for (int c = 1; c <= W + 1; c++) begin
            if ({Busy, Done} !== 2'b10) bd_bad = {Busy, Done};
            if (noise && c == 5) begin
                Start = 1'b1; We = 1'b1; HiLo = $urandom_range(0, 1);
                D1 = $urandom; D2 = $urandom; Op = $urandom_range(0, 7);
            end else begin
                Start = 1'b0; We = 1'b0;
            end
            tick();
        end
        chk({tag, " busy-window"}, bd_bad, 2'b10);
        chk({tag, " done-cycle"}, {Busy, Done}, 2'b01);
        chk({tag, " hilo"}, {HI, LO}, exp);
        {m_hi, m_lo} = exp;
    endtask

    task automatic write_hilo(input string tag, input logic sel, input logic [31:0] v);
        We = 1'b1; HiLo = sel; D1 = v;
        tick();
        We = 1'b0;
        if (sel) m_lo = v; else m_hi = v;
        chk(tag, {HI, LO}, {m_hi, m_lo});
    endtask

    initial begin
        resetn = 1'b0; D1 = '0; D2 = '0; Op = '0;
        Start = 1'b0; We = 1'b0; HiLo = 1'b0; if_exception = 1'b0;
        m_hi = '0; m_lo = '0;
        repeat (3) tick();
        chk("reset busy/done", {Busy, Done}, 2'b00);
        chk("reset hilo", {HI, LO}, 64'h0);
        @(negedge Clk);
        resetn = 1'b1;
        tick();

        // 1: MULT -3 * 7
        run_op("mult", 3'b001, 32'hFFFF_FFFD, 32'd7, 1'b0);
        chk("mult const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);
        // 2: MULTU max*max back-to-back with MADD
        run_op("multu", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("multu const", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
        run_op("madd", 3'b101, 32'd2, 32'd3, 1'b0);
        chk("madd const", {HI, LO}, 64'hFFFF_FFFE_0000_0007);
        // 3: signed divide and divide by zero
        run_op("div", 3'b011, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu0", 3'b010, 32'd7, 32'd0, 1'b0);
        chk("divu0 const", {HI, LO}, 64'h0000_0007_FFFF_FFFF);
        // 4: DIV overflow, MSUBU wrap
        run_op("divovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("divovf const", {HI, LO}, 64'h0000_0000_8000_0000);
        write_hilo("wr hi0", 1'b0, 32'h0);
        write_hilo("wr lo5", 1'b1, 32'h5);
        run_op("msubu", 3'b110, 32'd3, 32'd3, 1'b0);
        chk("msubu const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFC);

        // 5: abort in CALC cycle 10
        write_hilo("wr hi11", 1'b0, 32'h11);
        write_hilo("wr lo22", 1'b1, 32'h22);
        Op = 3'b001; D1 = $urandom; D2 = $urandom; Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (9) tick();
        if_exception = 1'b1;
        tick();
        if_exception = 1'b0;
        chk("abort calc busy/done", {Busy, Done}, 2'b00);
        chk("abort calc hilo", {HI, LO}, 64'h0000_0011_0000_0022);
        tick();
        chk("abort calc no done", {Busy, Done}, 2'b00);

        // abort arriving in FIX
        Op = 3'b000; D1 = 32'd9; D2 = 32'd9; Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (W) tick();
        chk("in fix busy", {Busy, Done}, 2'b10);
        if_exception = 1'b1;
        tick();
        if_exception = 1'b0;
        chk("abort fix busy/done", {Busy, Done}, 2'b00);
        chk("abort fix hilo", {HI, LO}, {m_hi, m_lo});

        // Start + exception in IDLE: no launch
        Op = 3'b000; D1 = 32'd4; D2 = 32'd4; Start = 1'b1; if_exception = 1'b1;
        tick();
        Start = 1'b0; if_exception = 1'b0;
        chk("exc refuse busy", {Busy, Done}, 2'b00);
        tick();
        chk("exc refuse hilo", {HI, LO, Busy}, {m_hi, m_lo, 1'b0});

        // 6: We beats Start in the same cycle
        We = 1'b1; HiLo = 1'b1; D1 = 32'hABCD; D2 = 32'd3; Op = 3'b000; Start = 1'b1;
        tick();
        We = 1'b0; Start = 1'b0;
        m_lo = 32'hABCD;
        chk("we+start lo", {HI, LO}, {m_hi, m_lo});
        chk("we+start no launch", {Busy, Done}, 2'b00);
        tick();
        chk("we+start still idle", {Busy, Done}, 2'b00);

        // Start/We while Busy are ignored
        run_op("noise madd", 3'b101, 32'h1234_5678, 32'hFEDC_BA98, 1'b1);
        tick();
        chk("noise no relaunch", {Busy, Done}, 2'b00);

        // resetn low mid-CALC
        Op = 3'b011; D1 = $urandom; D2 = 32'd5; Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (4) tick();
        #2 resetn = 1'b0;
        #1;
        chk("async rst busy/done", {Busy, Done}, 2'b00);
        chk("async rst hilo", {HI, LO}, 64'h0);
        m_hi = '0; m_lo = '0;
        @(negedge Clk);
        resetn = 1'b1;
        tick();

        // Randomized ops against the reference model
        for (int i = 0; i < 30; i++) begin
            logic [2:0]  rop;
            logic [31:0] ra, rb;
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) write_hilo("rand wr", 1'($urandom_range(0, 1)), $urandom);
            run_op("rand", rop, ra, rb, ($urandom_range(0, 2) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
